// File: rtl/chip_cycle.sv
// Access-cycle former for the YM2203 pair and SAA1099 on the internal data bus.
// Turns single-cycle host requests into registered strobe sequences, with a one-entry pending buffer.
module chip_cycle #(
  parameter int unsigned YM_SETUP  = 1,
  parameter int unsigned YM_PULSE  = 14,
  parameter int unsigned SAA_CS2WR = 3,
  parameter int unsigned SAA_PULSE = 6,
  parameter int unsigned HOLD      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_wraddr_i,
  input  logic       req_wrdata_i,
  input  logic       req_rddata_i,
  input  logic [7:0] req_data_i,
  input  logic       ym_sel_i,
  input  logic       ym_stat_i,
  input  logic       saa_sel_i,
  output logic       busy_o,
  output logic       ovr_o,
  output logic       yma0_o,
  output logic       ymcs0_n_o,
  output logic       ymcs1_n_o,
  output logic       ymrd_n_o,
  output logic       ymwr_n_o,
  output logic       saaa0_o,
  output logic       saacs_n_o,
  output logic       saawr_n_o,
  output logic [7:0] d_out_o,
  output logic       d_oe_o,
  input  logic [7:0] d_in_i,
  output logic [7:0] rd_data_o,
  output logic       rd_valid_o
);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;
  typedef enum logic [1:0] {OpWrAddr, OpWrData, OpRead} op_e;

  typedef struct packed {
    op_e        op;
    logic       ym_sel;
    logic       ym_stat;
    logic       saa;
    logic [7:0] data;
  } req_t;

  // Counters hold (length - 1) and the state advances when they reach zero.
  localparam logic [3:0] YmSetupLd  = 4'(YM_SETUP - 1);
  localparam logic [3:0] YmPulseLd  = 4'(YM_PULSE - 1);
  localparam logic [3:0] SaaCs2WrLd = 4'(SAA_CS2WR - 1);
  localparam logic [3:0] SaaPulseLd = 4'(SAA_PULSE - 1);
  localparam logic [3:0] HoldLd     = 4'(HOLD - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  req_t       cur_q, cur_d;
  req_t       pend_q, pend_d;
  logic       pend_v_q, pend_v_d;
  logic [7:0] rd_data_d;
  logic       rd_valid_d;
  logic       ovr_d;
  logic       busy_d;

  logic       new_v, multi, consume;
  req_t       new_req;

  always_comb begin
    new_v = req_wraddr_i | req_wrdata_i | req_rddata_i;
    multi = (req_wraddr_i & req_wrdata_i) | (req_wraddr_i & req_rddata_i) |
            (req_wrdata_i & req_rddata_i);
    new_req.op      = req_wrdata_i ? OpWrData : (req_wraddr_i ? OpWrAddr : OpRead);
    new_req.ym_sel  = ym_sel_i;
    new_req.ym_stat = ym_stat_i;
    new_req.saa     = saa_sel_i;
    new_req.data    = req_data_i;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    rd_data_d  = rd_data_o;
    rd_valid_d = 1'b0;
    consume    = 1'b0;

    unique case (state_q)
      StIdle: consume = pend_v_q;
      StSetup: begin
        if (cnt_q == 4'd0) begin
          state_d = StStrobe;
          cnt_d   = cur_q.saa ? SaaPulseLd : YmPulseLd;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StStrobe: begin
        if (cnt_q == 4'd0) begin
          state_d = StHold;
          cnt_d   = HoldLd;
          // Last strobe cycle: rd_n is still low at this edge.
          if (cur_q.op == OpRead) begin
            rd_data_d  = d_in_i;
            rd_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
          consume = pend_v_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (consume) begin
      if (pend_q.saa && pend_q.op == OpRead) begin
        // The SAA1099 has no read path; answer with an idle bus value.
        rd_data_d  = 8'hFF;
        rd_valid_d = 1'b1;
        state_d    = StIdle;
      end else begin
        state_d = StSetup;
        cur_d   = pend_q;
        cnt_d   = pend_q.saa ? SaaCs2WrLd : YmSetupLd;
      end
    end

    pend_v_d = pend_v_q & ~consume;
    pend_d   = pend_q;
    ovr_d    = multi;
    if (new_v) begin
      if (!pend_v_d) begin
        pend_v_d = 1'b1;
        pend_d   = new_req;
      end else begin
        ovr_d = 1'b1;
      end
    end
    busy_d = (state_d != StIdle) | pend_v_d;
  end

  // Strobe values for the upcoming state, registered so outputs are glitch-free.
  logic       act, ym_act, saa_act, is_wr, strb;
  logic       yma0_d, ymcs0_n_d, ymcs1_n_d, ymrd_n_d, ymwr_n_d;
  logic       saaa0_d, saacs_n_d, saawr_n_d, d_oe_d;
  logic [7:0] d_out_d;

  always_comb begin
    act       = state_d != StIdle;
    ym_act    = act & ~cur_d.saa;
    saa_act   = act & cur_d.saa;
    is_wr     = cur_d.op != OpRead;
    strb      = state_d == StStrobe;
    yma0_d    = ym_act & ((cur_d.op == OpWrData) | ((cur_d.op == OpRead) & ~cur_d.ym_stat));
    ymcs0_n_d = ~(ym_act & strb & ~cur_d.ym_sel);
    ymcs1_n_d = ~(ym_act & strb & cur_d.ym_sel);
    ymwr_n_d  = ~(ym_act & strb & is_wr);
    ymrd_n_d  = ~(ym_act & strb & ~is_wr);
    saaa0_d   = saa_act & (cur_d.op == OpWrAddr);
    saacs_n_d = ~(saa_act & ((state_d == StSetup) | strb));
    saawr_n_d = ~(saa_act & strb);
    d_oe_d    = act & is_wr;
    d_out_d   = d_oe_d ? cur_d.data : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      cur_q      <= '0;
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      busy_o     <= 1'b0;
      ovr_o      <= 1'b0;
      yma0_o     <= 1'b0;
      ymcs0_n_o  <= 1'b1;
      ymcs1_n_o  <= 1'b1;
      ymrd_n_o   <= 1'b1;
      ymwr_n_o   <= 1'b1;
      saaa0_o    <= 1'b0;
      saacs_n_o  <= 1'b1;
      saawr_n_o  <= 1'b1;
      d_out_o    <= 8'h00;
      d_oe_o     <= 1'b0;
      rd_data_o  <= 8'h00;
      rd_valid_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      busy_o     <= busy_d;
      ovr_o      <= ovr_d;
      yma0_o     <= yma0_d;
      ymcs0_n_o  <= ymcs0_n_d;
      ymcs1_n_o  <= ymcs1_n_d;
      ymrd_n_o   <= ymrd_n_d;
      ymwr_n_o   <= ymwr_n_d;
      saaa0_o    <= saaa0_d;
      saacs_n_o  <= saacs_n_d;
      saawr_n_o  <= saawr_n_d;
      d_out_o    <= d_out_d;
      d_oe_o     <= d_oe_d;
      rd_data_o  <= rd_data_d;
      rd_valid_o <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_chip_cycle.sv
// Directed bench for chip_cycle: YM write/read, SAA pair, overrun, reset mid-strobe, SAA read.
module tb_chip_cycle;

  logic       clk, rst_n;
  logic       req_wraddr, req_wrdata, req_rddata;
  logic [7:0] req_data;
  logic       ym_sel, ym_stat, saa_sel;
  logic       busy, ovr, yma0, ymcs0_n, ymcs1_n, ymrd_n, ymwr_n;
  logic       saaa0, saacs_n, saawr_n, d_oe, rd_valid;
  logic [7:0] d_out, d_in, rd_data;

  int total = 0;
  int bad   = 0;
  int wr_falls = 0;
  int rv_count = 0;
  int n;

  chip_cycle dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_wraddr_i (req_wraddr),
    .req_wrdata_i (req_wrdata),
    .req_rddata_i (req_rddata),
    .req_data_i   (req_data),
    .ym_sel_i     (ym_sel),
    .ym_stat_i    (ym_stat),
    .saa_sel_i    (saa_sel),
    .busy_o       (busy),
    .ovr_o        (ovr),
    .yma0_o       (yma0),
    .ymcs0_n_o    (ymcs0_n),
    .ymcs1_n_o    (ymcs1_n),
    .ymrd_n_o     (ymrd_n),
    .ymwr_n_o     (ymwr_n),
    .saaa0_o      (saaa0),
    .saacs_n_o    (saacs_n),
    .saawr_n_o    (saawr_n),
    .d_out_o      (d_out),
    .d_oe_o       (d_oe),
    .d_in_i       (d_in),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid)
  );

  always #5 clk = ~clk;

  always @(negedge ymwr_n) if (rst_n) wr_falls++;
  always @(posedge clk) if (rd_valid === 1'b1) rv_count++;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // kind: 0 wraddr, 1 wrdata, 2 rddata; returns 1ns after the capture edge.
  task automatic pulse(input int kind, input logic [7:0] d);
    req_data = d;
    req_wraddr = (kind == 0);
    req_wrdata = (kind == 1);
    req_rddata = (kind == 2);
    step(1);
    req_wraddr = 1'b0;
    req_wrdata = 1'b0;
    req_rddata = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy === 1'b1 && k < 100) begin
      step(1);
      k++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    clk = 0; rst_n = 0;
    req_wraddr = 0; req_wrdata = 0; req_rddata = 0; req_data = 8'h00;
    ym_sel = 0; ym_stat = 0; saa_sel = 0; d_in = 8'h00;
    #12;
    check("rst_ymcs0", ymcs0_n, 1'b1);
    check("rst_ymwr", ymwr_n, 1'b1);
    check("rst_saacs", saacs_n, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_doe", d_oe, 1'b0);
    check("rst_rdvalid", rd_valid, 1'b0);
    @(posedge clk); #1 rst_n = 1;
    step(1);

    // YM #0 address write
    pulse(0, 8'h27);
    check("w_busy", busy, 1'b1);
    step(1);
    check("w_setup_yma0", yma0, 1'b0);
    check("w_setup_doe", d_oe, 1'b1);
    check("w_setup_dout", d_out, 8'h27);
    check("w_setup_cs0", ymcs0_n, 1'b1);
    step(1);
    check("w_cs0_low", ymcs0_n, 1'b0);
    check("w_wr_low", ymwr_n, 1'b0);
    check("w_cs1_high", ymcs1_n, 1'b1);
    n = 0;
    while (ymcs0_n === 1'b0 && n < 20) begin n++; step(1); end
    check("w_cs0_len", 8'(n), 8'd14);
    check("w_hold_wr", ymwr_n, 1'b1);
    check("w_hold_doe", d_oe, 1'b1);
    check("w_hold_dout", d_out, 8'h27);
    step(1);
    check("w_end_busy", busy, 1'b0);
    check("w_end_doe", d_oe, 1'b0);

    // YM #1 data read; config changes after capture must be ignored
    ym_sel = 1; ym_stat = 0; d_in = 8'hA5; rv_count = 0;
    pulse(2, 8'h00);
    ym_sel = 0; ym_stat = 1;
    step(1);
    check("r_yma0", yma0, 1'b1);
    check("r_doe", d_oe, 1'b0);
    step(1);
    check("r_cs1_low", ymcs1_n, 1'b0);
    check("r_rd_low", ymrd_n, 1'b0);
    check("r_cs0_high", ymcs0_n, 1'b1);
    n = 0;
    while (ymrd_n === 1'b0 && n < 20) begin n++; step(1); end
    check("r_rd_len", 8'(n), 8'd14);
    check("r_valid", rd_valid, 1'b1);
    check("r_data", rd_data, 8'hA5);
    step(1);
    check("r_valid_end", rd_valid, 1'b0);
    check("r_busy_end", busy, 1'b0);
    check("r_valid_count", 8'(rv_count), 8'd1);

    // SAA write pair, second request pending, no gap between cycles
    saa_sel = 1;
    pulse(0, 8'h1C);
    step(1);
    check("s1_cs_low", saacs_n, 1'b0);
    check("s1_wr_high", saawr_n, 1'b1);
    check("s1_a0", saaa0, 1'b1);
    check("s1_dout", d_out, 8'h1C);
    step(2);
    pulse(1, 8'h01);
    check("s1_wr_low", saawr_n, 1'b0);
    step(5);
    check("s1_wr_last", saawr_n, 1'b0);
    step(1);
    check("s1_hold_wr", saawr_n, 1'b1);
    check("s1_hold_cs", saacs_n, 1'b1);
    step(1);
    check("s2_cs_low", saacs_n, 1'b0);
    check("s2_a0", saaa0, 1'b0);
    check("s2_dout", d_out, 8'h01);
    step(2);
    check("s2_wr_high", saawr_n, 1'b1);
    step(1);
    check("s2_wr_low", saawr_n, 1'b0);
    step(6);
    check("s2_hold_wr", saawr_n, 1'b1);
    step(1);
    check("s2_busy_end", busy, 1'b0);

    // Overrun: three requests during one YM cycle
    saa_sel = 0; ym_sel = 0; wr_falls = 0;
    pulse(0, 8'h10);
    pulse(1, 8'h11);
    check("o_ovr_none", ovr, 1'b0);
    pulse(0, 8'h20);
    check("o_ovr_pulse", ovr, 1'b1);
    step(1);
    check("o_ovr_clear", ovr, 1'b0);
    wait_idle();
    check("o_two_cycles", 8'(wr_falls), 8'd2);

    // Simultaneous requests: wrdata wins, ovr pulses
    req_data = 8'h55; req_wraddr = 1; req_wrdata = 1;
    step(1);
    req_wraddr = 0; req_wrdata = 0;
    check("m_ovr", ovr, 1'b1);
    step(1);
    check("m_yma0", yma0, 1'b1);
    check("m_dout", d_out, 8'h55);
    wait_idle();

    // Reset during the 5th strobe cycle of a read
    ym_stat = 1; rv_count = 0;
    pulse(2, 8'h00);
    step(1);
    step(5);
    check("x_rd_low", ymrd_n, 1'b0);
    rst_n = 0;
    #1;
    check("x_cs0", ymcs0_n, 1'b1);
    check("x_rd", ymrd_n, 1'b1);
    check("x_busy", busy, 1'b0);
    check("x_doe", d_oe, 1'b0);
    step(2);
    rst_n = 1;
    step(20);
    check("x_no_valid", 8'(rv_count), 8'd0);
    pulse(0, 8'h33);
    step(2);
    n = 0;
    while (ymcs0_n === 1'b0 && n < 20) begin n++; step(1); end
    check("x_full_cycle", 8'(n), 8'd14);
    wait_idle();

    // SAA read: no strobes, immediate 8'hFF
    saa_sel = 1;
    pulse(2, 8'h00);
    check("sr_cs_idle", saacs_n, 1'b1);
    step(1);
    check("sr_valid", rd_valid, 1'b1);
    check("sr_data", rd_data, 8'hFF);
    check("sr_cs", saacs_n, 1'b1);
    check("sr_wr", saawr_n, 1'b1);
    check("sr_ymrd", ymrd_n, 1'b1);
    step(1);
    check("sr_valid_end", rd_valid, 1'b0);
    check("sr_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chip_cycle.md
# chip_cycle

Access-cycle former on the chip side of the host bus decoder. It takes filtered single-cycle requests (write address, write data, read), each with its latched host byte, and turns them into correctly timed strobe sequences for the selected YM2203 (#0 or #1) or the SAA1099 on the internal data bus. It returns read data to the host side through a one-cycle valid pulse. It runs on the 56 MHz clock (Tc = 17.8 ns), with a one-entry pending buffer so that host accesses arriving during a cycle are not lost.

## Interface
Parameters:
- YM_SETUP, 1: Tc of address setup before YM cs/strobe.
- YM_PULSE, 14: Tc that YM cs_n and wr_n/rd_n are held low.
- SAA_CS2WR, 3: Tc that saacs_n is low before saawr_n falls.
- SAA_PULSE, 6: Tc that saawr_n is held low.
- HOLD, 1: Tc that address/data are held after the strobe rises (applies to YM and SAA).

Ports:
- clk  in  1  56 MHz clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  async active-low reset.
- req_wraddr / req_wrdata / req_rddata  in  1 each  one-cycle request pulses.
- req_data  in  8  host byte, valid with a write request.
- ym_sel, ym_stat, saa_sel  in  1 each  config; sampled when a request is captured.
- busy  out  1  high while a cycle runs or a request is pending.
- ovr  out  1  one-cycle pulse when a request is dropped.
- yma0, ymcs0_n, ymcs1_n, ymrd_n, ymwr_n  out  1 each  YM2203 strobes.
- saaa0, saacs_n, saawr_n  out  1 each  SAA1099 strobes.
- d_out  out  8  data to the internal bus.
- d_oe  out  1  internal bus drive enable.
- d_in  in  8  internal bus read-back.
- rd_data  out  8  last read byte.
- rd_valid  out  1  one-cycle pulse when rd_data updates.

## Operation
- **Reset values:** all *_n outputs are 1, yma0=0, saaa0=0, d_oe=0, d_out=0, rd_data=0, rd_valid=0, busy=0, ovr=0. The FSM goes to IDLE and pending is cleared.
- **Request capture:** a request is captured with type, req_data and the config bits.
  - More than one req_* high in one cycle: priority is wrdata > wraddr > rddata. The losers are dropped and ovr pulses.
- **FSM states:** IDLE, SETUP, STROBE, HOLD. A 4-bit down-counter is loaded on each state entry.
  - IDLE, request present (new or pending): go to SETUP.
  - SETUP: lasts YM_SETUP (YM) or SAA_CS2WR (SAA) cycles, then go to STROBE.
  - STROBE: lasts YM_PULSE or SAA_PULSE cycles, then go to HOLD.
  - HOLD: lasts HOLD cycles. Then go to SETUP if pending is valid (pending is consumed), else to IDLE.
- **YM cycle** (saa_sel=0):
  - Address: yma0=0 for wraddr; yma0=1 for wrdata; yma0=!ym_stat for rddata.
  - In SETUP, only yma0 is valid.
  - In STROBE, the chip-select ymcsN_n is low (N = ym_sel), plus ymwr_n (writes) or ymrd_n (reads).
  - In HOLD, all strobes are high and yma0/d_out are held.
- **SAA cycle** (saa_sel=1):
  - Address: saaa0=1 for wraddr, saaa0=0 for wrdata.
  - SETUP: saacs_n low. STROBE: saacs_n and saawr_n low. HOLD: both high.
  - A SAA read runs no bus cycle: rd_data=8'hFF and rd_valid pulses on the cycle after capture.
- **d_oe / d_out:** for writes, d_oe=1 and d_out=captured byte from SETUP entry through HOLD end. For reads, d_oe=0 throughout.
- **Read latch:** d_in is sampled on the last STROBE cycle (while ymrd_n is still low) into rd_data; rd_valid pulses on the following cycle.
- **Pending buffer:**
  - A request arriving while not IDLE is stored in pending if it is empty.
  - If pending is full, the new request is dropped and ovr pulses.
  - A request in the same cycle as pending is consumed in HOLD is stored (pending frees and refills).
- **Config changes:** changes to ym_sel/ym_stat/saa_sel after capture do not affect the running or pending cycle.
- **Reset mid-cycle:** all strobes rise asynchronously at once. No partial completion and no rd_valid.

## Timing
- Request at edge k (YM write):
  - yma0/d_oe are valid after edge k+1.
  - cs/wr are low from after edge k+1+YM_SETUP for YM_PULSE cycles.
  - HOLD follows; busy falls after edge k+1+YM_SETUP+YM_PULSE+HOLD.
- Defaults:
  - YM cycle: SETUP+STROBE+HOLD = 16 Tc (≈285 ns).
  - SAA cycle: 10 Tc.
- Back-to-back with pending: the next SETUP starts on the cycle after the last HOLD cycle; there are no idle cycles.
- Strobes are registered outputs, so there are no combinational glitches.

## Test plan
- **YM #0 address write:** reset, ym_sel=0, saa_sel=0, req_wraddr, req_data=8'h27 -> yma0=0, ymcs0_n and ymwr_n low for exactly 14 Tc, 1 Tc after SETUP. d_out=8'h27 with d_oe=1 through HOLD. ymcs1_n stays high.
- **YM #1 data read:** ym_sel=1, ym_stat=0, req_rddata, d_in=8'hA5 -> yma0=1, ymcs1_n and ymrd_n low for 14 Tc, d_oe=0. rd_data=8'hA5 with a single rd_valid pulse after ymrd_n rises.
- **SAA write pair:** saa_sel=1, req_wraddr(8'h1C) then req_wrdata(8'h01) issued 4 cycles later -> the second request goes to pending. Two 10-Tc cycles run with no gap. saaa0 is 1 then 0; saawr_n falls 3 Tc after saacs_n each time.
- **Overrun:** three requests within one YM cycle -> the first runs, the second is pending, the third is dropped with a one-cycle ovr. Exactly two bus cycles occur.
- **Reset mid-strobe:** assert rst_n=0 during the 5th STROBE cycle -> all *_n outputs go high immediately, d_oe=0, busy=0. No rd_valid. After release, the next request runs a full cycle.
- **SAA read:** saa_sel=1, req_rddata -> no strobes toggle; rd_data=8'hFF and rd_valid pulse on the next cycle.
